// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared encodings for the multi-cycle MIPS32 control path:
//                ALU operation codes, opcode/funct values, next-PC select
//                codes, controller states and decoded instruction classes.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

  // ALU operation codes driven on alu_op
  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_LUI = 4'd7;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // Next-PC select codes
  localparam logic [1:0] NPC_PC4    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;

  // Controller states
  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EXE  = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5
  } state_t;

  // Decoded instruction classes
  typedef enum logic [3:0] {
    CLS_RTYPE   = 4'd0,
    CLS_ADDIU   = 4'd1,
    CLS_ORI     = 4'd2,
    CLS_LUI     = 4'd3,
    CLS_LW      = 4'd4,
    CLS_SW      = 4'd5,
    CLS_BEQ     = 4'd6,
    CLS_J       = 4'd7,
    CLS_ILLEGAL = 4'd8
  } instr_cls_t;

endpackage
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mc_decode
//  Description : Combinational instruction decoder. Maps op/funct to an
//                instruction class plus the EXE-phase ALU controls.
//  Ports       : op, funct      - IR opcode and function fields
//                cls            - decoded instruction class
//                alu_op         - ALU operation used from EXE onward
//                alu_src_b      - 1 selects the extended immediate
//                ext_op         - 1 sign-extends the immediate
//                illegal        - encoding is not supported
//  Revision    : 1.0  initial release
// ============================================================================
module mc_decode
  import mips_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  output instr_cls_t  cls,
  output logic [3:0]  alu_op,
  output logic        alu_src_b,
  output logic        ext_op,
  output logic        illegal
);

  always_comb begin
    cls       = CLS_ILLEGAL;
    alu_op    = ALU_NOP;
    alu_src_b = 1'b0;
    ext_op    = 1'b0;
    case (op)
      OP_RTYPE: begin
        cls = CLS_RTYPE;
        case (funct)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUBU:         alu_op = ALU_SUB;
          FN_AND:          alu_op = ALU_AND;
          FN_OR:           alu_op = ALU_OR;
          FN_SLT:          alu_op = ALU_SLT;
          FN_SLL:          alu_op = ALU_SLL;
          default:         cls    = CLS_ILLEGAL;
        endcase
      end
      OP_ADDIU: begin
        cls = CLS_ADDIU; alu_op = ALU_ADD; alu_src_b = 1'b1; ext_op = 1'b1;
      end
      OP_ORI: begin
        cls = CLS_ORI; alu_op = ALU_OR; alu_src_b = 1'b1;
      end
      OP_LUI: begin
        cls = CLS_LUI; alu_op = ALU_LUI; alu_src_b = 1'b1;
      end
      OP_LW: begin
        cls = CLS_LW; alu_op = ALU_ADD; alu_src_b = 1'b1; ext_op = 1'b1;
      end
      OP_SW: begin
        cls = CLS_SW; alu_op = ALU_ADD; alu_src_b = 1'b1; ext_op = 1'b1;
      end
      OP_BEQ: begin
        cls = CLS_BEQ; alu_op = ALU_SUB;
      end
      OP_J: begin
        cls = CLS_J;
      end
      default: cls = CLS_ILLEGAL;
    endcase
    illegal = (cls == CLS_ILLEGAL);
  end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl
//  Description : Multi-cycle main controller. Sequences INIT/IF/ID/EXE/MEM/WB
//                and drives every datapath enable and mux select.
//  Ports       : clk, rst (async, active high)
//                op, funct, zero, mem_ready          - status inputs
//                pc_wr, ir_wr, reg_wr, mem_rd, mem_wr - write/access enables
//                alu_op, alu_src_b, ext_op           - ALU controls
//                reg_dst, mem_to_reg, npc_op         - datapath selects
//                illegal, instr_done                 - one-cycle status pulses
//  Revision    : 1.0  initial release
// ============================================================================
module mc_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       reg_wr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [3:0] alu_op,
  output logic       alu_src_b,
  output logic       ext_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] npc_op,
  output logic       illegal,
  output logic       instr_done
);

  state_t     r_state;
  state_t     w_next_state;
  instr_cls_t w_cls;
  logic [3:0] w_exe_alu_op;
  logic       w_exe_alu_src_b;
  logic       w_exe_ext_op;
  logic       w_dec_illegal;

  mc_decode u_decode (
    .op        (op),
    .funct     (funct),
    .cls       (w_cls),
    .alu_op    (w_exe_alu_op),
    .alu_src_b (w_exe_alu_src_b),
    .ext_op    (w_exe_ext_op),
    .illegal   (w_dec_illegal)
  );

  // The only flop in the controller. Outputs decode straight from it, so an
  // asserted reset silences every enable within the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_INIT;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    pc_wr        = 1'b0;
    ir_wr        = 1'b0;
    reg_wr       = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    alu_op       = ALU_NOP;
    alu_src_b    = 1'b0;
    ext_op       = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    npc_op       = NPC_PC4;
    illegal      = 1'b0;
    instr_done   = 1'b0;
    case (r_state)
      S_INIT: w_next_state = S_IF;
      S_IF: begin
        mem_rd = 1'b1;
        pc_wr  = mem_ready;
        ir_wr  = mem_ready;
        if (mem_ready) w_next_state = S_ID;
      end
      S_ID: begin
        if (w_dec_illegal) begin
          illegal      = 1'b1;
          w_next_state = S_IF;
        end else if (w_cls == CLS_J) begin
          pc_wr        = 1'b1;
          npc_op       = NPC_JUMP;
          instr_done   = 1'b1;
          w_next_state = S_IF;
        end else begin
          w_next_state = S_EXE;
        end
      end
      S_EXE: begin
        alu_op    = w_exe_alu_op;
        alu_src_b = w_exe_alu_src_b;
        ext_op    = w_exe_ext_op;
        if (w_cls == CLS_BEQ) begin
          pc_wr        = zero;
          npc_op       = NPC_BRANCH;
          instr_done   = 1'b1;
          w_next_state = S_IF;
        end else if (w_cls == CLS_LW || w_cls == CLS_SW) begin
          w_next_state = S_MEM;
        end else begin
          w_next_state = S_WB;
        end
      end
      S_MEM: begin
        // ALU controls are held so the computed address stays stable.
        alu_op    = w_exe_alu_op;
        alu_src_b = w_exe_alu_src_b;
        ext_op    = w_exe_ext_op;
        mem_rd    = (w_cls == CLS_LW);
        mem_wr    = (w_cls == CLS_SW);
        if (mem_ready) begin
          if (w_cls == CLS_SW) begin
            instr_done   = 1'b1;
            w_next_state = S_IF;
          end else begin
            w_next_state = S_WB;
          end
        end
      end
      S_WB: begin
        alu_op       = w_exe_alu_op;
        alu_src_b    = w_exe_alu_src_b;
        ext_op       = w_exe_ext_op;
        reg_wr       = 1'b1;
        instr_done   = 1'b1;
        reg_dst      = (w_cls == CLS_RTYPE);
        mem_to_reg   = (w_cls == CLS_LW);
        w_next_state = S_IF;
      end
      default: w_next_state = S_INIT;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_ctrl
//  Description : Self-checking bench for mc_ctrl. A per-instruction phase
//                model builds the expected output trace from the instruction
//                rules; the bench plays memory/IR and compares each cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_wr, ir_wr, reg_wr, mem_rd, mem_wr;
  logic [3:0] alu_op;
  logic       alu_src_b, ext_op, reg_dst, mem_to_reg;
  logic [1:0] npc_op;
  logic       illegal, instr_done;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_wr(pc_wr), .ir_wr(ir_wr), .reg_wr(reg_wr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .alu_op(alu_op), .alu_src_b(alu_src_b),
    .ext_op(ext_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .npc_op(npc_op), .illegal(illegal), .instr_done(instr_done)
  );

  // {pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, alu_op[3:0], alu_src_b, ext_op,
  //  reg_dst, mem_to_reg, npc_op[1:0], illegal, instr_done}
  logic [16:0] w_obs;
  assign w_obs = {pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, alu_op, alu_src_b,
                  ext_op, reg_dst, mem_to_reg, npc_op, illegal, instr_done};

  localparam logic [16:0] M_SRC  = 17'h00080;
  localparam logic [16:0] M_EXT  = 17'h00040;
  localparam logic [16:0] M_DST  = 17'h00020;
  localparam logic [16:0] M_M2R  = 17'h00010;
  localparam logic [16:0] M_NPC  = 17'h0000C;
  localparam logic [16:0] M_BASE = ~(M_SRC | M_EXT | M_DST | M_M2R | M_NPC);

  localparam logic [3:0] K_R = 4'd0, K_ADDIU = 4'd1, K_ORI = 4'd2, K_LUI = 4'd3;
  localparam logic [3:0] K_LW = 4'd4, K_SW = 4'd5, K_BEQ = 4'd6, K_J = 4'd7;
  localparam logic [3:0] K_ILL = 4'd8;

  typedef struct packed {
    logic [3:0] kind;
    logic [3:0] alu;
    logic       src;
    logic       ext;
    logic       ext_care;
  } ins_t;

  typedef struct packed {
    logic        mr;
    logic        z;
    logic [2:0]  ph;
    logic [16:0] exp;
    logic [16:0] care;
  } cyc_t;

  cyc_t        g_plan[$];
  logic [16:0] g_obs[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic string ph_name(input logic [2:0] p);
    case (p)
      3'd0: return "IF";
      3'd1: return "ID";
      3'd2: return "EXE";
      3'd3: return "MEM";
      default: return "WB";
    endcase
  endfunction

  function automatic logic [16:0] ov(
    input logic pc, input logic ir, input logic rw, input logic mr,
    input logic mw, input logic [3:0] alu, input logic src, input logic ext,
    input logic dst, input logic m2r, input logic [1:0] npc,
    input logic ill, input logic done);
    return {pc, ir, rw, mr, mw, alu, src, ext, dst, m2r, npc, ill, done};
  endfunction

  // Instruction table: class, EXE ALU op, immediate select, extension mode.
  function automatic ins_t ref_decode(input logic [5:0] o, input logic [5:0] f);
    ins_t d;
    d = '{K_ILL, 4'd0, 1'b0, 1'b0, 1'b0};
    case (o)
      6'b000000:
        case (f)
          6'b100000, 6'b100001: d = '{K_R, 4'd1, 1'b0, 1'b0, 1'b0};
          6'b100011:            d = '{K_R, 4'd2, 1'b0, 1'b0, 1'b0};
          6'b100100:            d = '{K_R, 4'd3, 1'b0, 1'b0, 1'b0};
          6'b100101:            d = '{K_R, 4'd4, 1'b0, 1'b0, 1'b0};
          6'b101010:            d = '{K_R, 4'd5, 1'b0, 1'b0, 1'b0};
          6'b000000:            d = '{K_R, 4'd6, 1'b0, 1'b0, 1'b0};
          default:              d = '{K_ILL, 4'd0, 1'b0, 1'b0, 1'b0};
        endcase
      6'b001001: d = '{K_ADDIU, 4'd1, 1'b1, 1'b1, 1'b1};
      6'b001101: d = '{K_ORI,   4'd4, 1'b1, 1'b0, 1'b1};
      6'b001111: d = '{K_LUI,   4'd7, 1'b1, 1'b0, 1'b0};
      6'b100011: d = '{K_LW,    4'd1, 1'b1, 1'b1, 1'b1};
      6'b101011: d = '{K_SW,    4'd1, 1'b1, 1'b1, 1'b1};
      6'b000100: d = '{K_BEQ,   4'd2, 1'b0, 1'b0, 1'b0};
      6'b000010: d = '{K_J,     4'd0, 1'b0, 1'b0, 1'b0};
      default:   d = '{K_ILL,   4'd0, 1'b0, 1'b0, 1'b0};
    endcase
    return d;
  endfunction

  // Builds the expected phase trace of one instruction, drives it and
  // records what the DUT showed in every cycle. Starts at the IF cycle.
  task automatic run_instr(input logic [5:0] i_op, input logic [5:0] i_fn,
                           input int if_st, input int mem_st, input logic br_z);
    ins_t d;
    cyc_t e;
    cyc_t plan[$];
    logic is_lw, is_sw, is_beq;
    d      = ref_decode(i_op, i_fn);
    is_lw  = (d.kind == K_LW);
    is_sw  = (d.kind == K_SW);
    is_beq = (d.kind == K_BEQ);
    for (int k = 0; k <= if_st; k++) begin
      e = '0; e.ph = 3'd0; e.mr = (k == if_st); e.z = 1'($urandom);
      e.exp  = ov(e.mr, e.mr, 0, 1, 0, 4'd0, 0, 0, 0, 0, 2'd0, 0, 0);
      e.care = M_BASE | M_NPC;
      plan.push_back(e);
    end
    e = '0; e.ph = 3'd1; e.mr = 1'($urandom); e.z = 1'($urandom); e.care = M_BASE;
    if (d.kind == K_J) begin
      e.exp  = ov(1, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 2'd2, 0, 1);
      e.care = M_BASE | M_NPC;
    end else if (d.kind == K_ILL) begin
      e.exp  = ov(0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 2'd0, 1, 0);
    end
    plan.push_back(e);
    if (d.kind != K_J && d.kind != K_ILL) begin
      e = '0; e.ph = 3'd2; e.mr = 1'($urandom);
      e.z    = is_beq ? br_z : 1'($urandom);
      e.exp  = ov(is_beq & e.z, 0, 0, 0, 0, d.alu, d.src, d.ext, 0, 0,
                  is_beq ? 2'd1 : 2'd0, 0, is_beq);
      e.care = M_BASE | (is_beq ? M_NPC : M_SRC) | (d.ext_care ? M_EXT : 17'h0);
      plan.push_back(e);
      if (is_lw || is_sw) begin
        for (int k = 0; k <= mem_st; k++) begin
          e = '0; e.ph = 3'd3; e.mr = (k == mem_st); e.z = 1'($urandom);
          e.exp  = ov(0, 0, 0, is_lw, is_sw, d.alu, 0, 0, 0, 0, 2'd0, 0,
                      is_sw & (k == mem_st));
          e.care = M_BASE;
          plan.push_back(e);
        end
      end
      if (!is_beq && !is_sw) begin
        e = '0; e.ph = 3'd4; e.mr = 1'($urandom); e.z = 1'($urandom);
        e.exp  = ov(0, 0, 1, 0, 0, d.alu, 0, 0, d.kind == K_R, is_lw, 2'd0, 0, 1);
        e.care = M_BASE | M_DST | M_M2R;
        plan.push_back(e);
      end
    end
    op = i_op; funct = i_fn;
    foreach (plan[i]) begin
      mem_ready = plan[i].mr;
      zero      = plan[i].z;
      @(negedge clk);
      g_plan.push_back(plan[i]);
      g_obs.push_back(w_obs);
      @(posedge clk); #1;
    end
  endtask

  // Leaves the bench #1 after the edge that moves INIT to IF.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    g_plan.delete();
    g_obs.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; op = '0; funct = '0; zero = 1'b1; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (w_obs !== 17'h0) begin
      n_fail++; $display("FAIL reset_hold: got %b expected all zero", w_obs);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (w_obs !== 17'h0) begin
      n_fail++; $display("FAIL init_state: got %b expected all zero", w_obs);
    end
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({pc_wr, ir_wr, mem_rd, npc_op} !== 5'b00100) begin
      n_fail++;
      $display("FAIL if_stall: got pc_wr/ir_wr/mem_rd/npc=%b expected 00100",
               {pc_wr, ir_wr, mem_rd, npc_op});
    end
  endtask

  task automatic test_addu();
    int di;
    do_reset();
    run_instr(6'b000000, 6'b100001, 0, 0, 1'b0);
    foreach (g_plan[i]) begin
      n_tests++;
      if ((g_obs[i] & g_plan[i].care) !== (g_plan[i].exp & g_plan[i].care)) begin
        n_fail++;
        $display("FAIL addu cycle %0d %s: got %b expected %b care %b", i,
                 ph_name(g_plan[i].ph), g_obs[i], g_plan[i].exp, g_plan[i].care);
      end
    end
    di = -1;
    foreach (g_obs[i]) if (g_obs[i][0] && di < 0) di = i;
    n_tests++;
    if (di != 3) begin  // IF is cycle 2 after release, so index 3 is cycle 5
      n_fail++; $display("FAIL addu_done_cycle: got index %0d expected 3", di);
    end
  endtask

  task automatic test_lw_stall();
    int di;
    int nrd;
    do_reset();
    run_instr(6'b100011, 6'($urandom), 0, 2, 1'b0);
    foreach (g_plan[i]) begin
      n_tests++;
      if ((g_obs[i] & g_plan[i].care) !== (g_plan[i].exp & g_plan[i].care)) begin
        n_fail++;
        $display("FAIL lw cycle %0d %s: got %b expected %b care %b", i,
                 ph_name(g_plan[i].ph), g_obs[i], g_plan[i].exp, g_plan[i].care);
      end
    end
    di = -1; nrd = 0;
    foreach (g_obs[i]) begin
      if (g_obs[i][0] && di < 0) di = i;
      if (i >= 3 && g_obs[i][13]) nrd++;
    end
    n_tests++;
    if (di != 6 || nrd != 3) begin
      n_fail++;
      $display("FAIL lw_timing: got done index %0d mem_rd cycles %0d expected 6 and 3",
               di, nrd);
    end
  endtask

  task automatic test_beq();
    int dq[$];
    do_reset();
    run_instr(6'b000100, 6'($urandom), 0, 0, 1'b1);
    run_instr(6'b000100, 6'($urandom), 0, 0, 1'b0);
    foreach (g_plan[i]) begin
      n_tests++;
      if ((g_obs[i] & g_plan[i].care) !== (g_plan[i].exp & g_plan[i].care)) begin
        n_fail++;
        $display("FAIL beq cycle %0d %s: got %b expected %b care %b", i,
                 ph_name(g_plan[i].ph), g_obs[i], g_plan[i].exp, g_plan[i].care);
      end
    end
    foreach (g_obs[i]) if (g_obs[i][0]) dq.push_back(i);
    n_tests++;
    if (dq.size() != 2 || dq[0] != 2 || dq[1] != 5) begin
      n_fail++; $display("FAIL beq_timing: got %0d done pulses, expected at 2 and 5",
                         dq.size());
    end
  endtask

  task automatic test_j_illegal();
    int dq[$];
    int iq[$];
    int nalu;
    do_reset();
    run_instr(6'b000010, 6'($urandom), 1, 0, 1'b0);
    run_instr(6'b111111, 6'($urandom), 0, 0, 1'b0);
    run_instr(6'b000000, 6'b000010, 0, 0, 1'b0);
    foreach (g_plan[i]) begin
      n_tests++;
      if ((g_obs[i] & g_plan[i].care) !== (g_plan[i].exp & g_plan[i].care)) begin
        n_fail++;
        $display("FAIL j_ill cycle %0d %s: got %b expected %b care %b", i,
                 ph_name(g_plan[i].ph), g_obs[i], g_plan[i].exp, g_plan[i].care);
      end
    end
    nalu = 0;
    foreach (g_obs[i]) begin
      if (g_obs[i][0]) dq.push_back(i);
      if (g_obs[i][1]) iq.push_back(i);
      if (g_obs[i][11:8] != 4'd0) nalu++;
    end
    n_tests++;
    // j: IF stall, IF, ID(done); illegal: IF, ID(illegal); repeated
    if (dq.size() != 1 || dq[0] != 2 || iq.size() != 2 || iq[0] != 4 ||
        iq[1] != 6 || nalu != 0) begin
      n_fail++;
      $display("FAIL j_ill_timing: got %0d done %0d illegal %0d alu cycles expected 1 2 0",
               dq.size(), iq.size(), nalu);
    end
  endtask

  task automatic test_reset_mid_sw();
    do_reset();
    op = 6'b101011; funct = 6'($urandom);
    mem_ready = 1'b1; zero = 1'b0;
    @(posedge clk); #1;                  // IF -> ID
    mem_ready = 1'b0;
    @(posedge clk); #1;                  // ID -> EXE
    @(posedge clk); #1;                  // EXE -> MEM
    @(negedge clk);
    n_tests++;
    if (mem_wr !== 1'b1) begin
      n_fail++; $display("FAIL sw_mem_wr: got %b expected 1", mem_wr);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (w_obs !== 17'h0) begin
      n_fail++; $display("FAIL async_reset: got %b expected all zero", w_obs);
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (w_obs !== 17'h0) begin
      n_fail++; $display("FAIL post_reset_init: got %b expected all zero", w_obs);
    end
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({mem_rd, pc_wr, mem_wr, reg_wr} !== 4'b1000) begin
      n_fail++; $display("FAIL if_resume: got mem_rd/pc_wr/mem_wr/reg_wr=%b expected 1000",
                         {mem_rd, pc_wr, mem_wr, reg_wr});
    end
  endtask

  task automatic test_random();
    logic [5:0] r_fn[7];
    logic [5:0] i_ops[7];
    logic [5:0] o;
    logic [5:0] f;
    int sel;
    int nboth;
    r_fn  = '{6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
              6'b101010, 6'b000000};
    i_ops = '{6'b001001, 6'b001101, 6'b001111, 6'b100011, 6'b101011,
              6'b000100, 6'b000010};
    do_reset();
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 11);
      f   = 6'($urandom);
      if (sel < 4) begin
        o = 6'b000000; f = r_fn[$urandom_range(0, 6)];
      end else if (sel < 11) begin
        o = i_ops[sel - 4];
      end else begin
        case ($urandom_range(0, 2))
          0: o = 6'b111111;
          1: begin o = 6'b000000; f = 6'b000010; end
          default: o = 6'b000011;
        endcase
      end
      run_instr(o, f, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
    end
    foreach (g_plan[i]) begin
      n_tests++;
      if ((g_obs[i] & g_plan[i].care) !== (g_plan[i].exp & g_plan[i].care)) begin
        n_fail++;
        $display("FAIL random cycle %0d %s: got %b expected %b care %b", i,
                 ph_name(g_plan[i].ph), g_obs[i], g_plan[i].exp, g_plan[i].care);
      end
    end
    nboth = 0;
    foreach (g_obs[i]) if (g_obs[i][1] && g_obs[i][0]) nboth++;
    n_tests++;
    if (nboth != 0) begin
      n_fail++; $display("FAIL done_illegal_exclusive: got %0d overlaps expected 0", nboth);
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_stall();
    test_beq();
    test_j_illegal();
    test_reset_mid_sw();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
